uart_tx: RTL

UART transmitter: the transmit end of the same 8-bit serial link the LiDAR design already receives on. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each byte as start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It sits between command/telemetry logic and the board TX pin.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_fifo.sv | 69 ++++++
 rtl/uart_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                         |
// | Brief    : Shared UART state encodings, parity modes and baud arithmetic.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clocks per bit; truncating division, shared with the receiver.
  function automatic int baud_ticks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                     |
// | Brief    : Small synchronous FIFO buffering bytes ahead of the serialiser.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [WIDTH-1:0]                 wr_data,
  input  logic                             rd_en,
  output logic [WIDTH-1:0]                 rd_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cw = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cw-1:0] c_full_count = c_cw'(FIFO_DEPTH);

  generate
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == c_full_count);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A pop on the same edge does not make room for a write while full.
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx                                                          |
// | Brief    : FIFO-buffered 8-bit UART transmitter, optional parity, 1/2 stop. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy
);

  localparam int              c_baud_ticks = baud_ticks(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0]     c_bit_last   = 16'(c_baud_ticks - 1);
  localparam logic [2:0]      c_stop_last  = 3'(STOP_BITS - 1);
  localparam int              c_cw         = $clog2(FIFO_DEPTH + 1);

  generate
    if ((PARITY < PAR_NONE) || (PARITY > PAR_ODD) || (STOP_BITS < 1) || (STOP_BITS > 2)
        || (c_baud_ticks < 1)) begin : g_param_check
      $error("uart_tx: PARITY must be 0..2, STOP_BITS 1 or 2, CLK_FREQ >= BAUD_RATE");
    end
  endgenerate

  tx_state_t         r_state;
  logic [15:0]       r_bit_timer;
  logic [2:0]        r_bit_index;
  logic [7:0]        r_shift;
  logic              r_serial;

  logic              w_full;
  logic              w_empty;
  logic [c_cw-1:0]   w_count;
  logic [7:0]        w_head;
  logic              w_bit_end;
  logic              w_stop_done;
  logic              w_pop;
  logic              w_parity;

  assign w_bit_end   = (r_bit_timer == c_bit_last);
  assign w_stop_done = w_bit_end && (r_bit_index == c_stop_last);
  assign w_parity    = (PARITY == PAR_ODD) ? ~^r_shift : ^r_shift;

  // Pops happen only when a new frame is launched, from IDLE or straight out of STOP.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = (w_count != '0);
      ST_STOP: w_pop = w_stop_done && (w_count != '0);
      default: w_pop = 1'b0;
    endcase
  end

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (tx_valid && tx_ready),
    .wr_data (tx_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_timer <= '0;
      r_bit_index <= '0;
      r_shift     <= '0;
      r_serial    <= 1'b1;
    end else begin
      r_bit_timer <= w_bit_end ? 16'd0 : r_bit_timer + 16'd1;
      case (r_state)
        ST_IDLE: begin
          r_bit_timer <= '0;
          r_serial    <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_head;
            r_serial <= 1'b0;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_bit_index <= '0;
            r_serial    <= r_shift[0];
            r_state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_index == 3'd7) begin
              r_bit_index <= '0;
              if (PARITY != PAR_NONE) begin
                r_serial <= w_parity;
                r_state  <= ST_PARITY;
              end else begin
                r_serial <= 1'b1;
                r_state  <= ST_STOP;
              end
            end else begin
              r_bit_index <= r_bit_index + 3'd1;
              r_serial    <= r_shift[r_bit_index + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_bit_index <= '0;
            r_serial    <= 1'b1;
            r_state     <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (!w_stop_done) begin
              r_bit_index <= r_bit_index + 3'd1;
            end else begin
              r_bit_index <= '0;
              if (w_pop) begin
                r_shift  <= w_head;
                r_serial <= 1'b0;
                r_state  <= ST_START;
              end else begin
                r_state  <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          r_serial <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_serial = r_serial;
  assign tx_ready  = !w_full;
  assign tx_busy   = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire
